// File: rtl/polygon_area_acc.sv
// Shoelace accumulator for one fence vertex set: reports twice the enclosed
// area and the winding direction once per N_VERT vertices.
module polygon_area_acc #(
    parameter int unsigned N_VERT  = 6,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned ACC_W   = 2 * COORD_W + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [COORD_W-1:0]   inX,
    input  logic [COORD_W-1:0]   inY,
    output logic [2*COORD_W:0]   dbl_area,
    output logic                 ccw,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 drop_err
);

    localparam int unsigned PROD_W = 2 * COORD_W;
    localparam int unsigned AREA_W = 2 * COORD_W + 1;
    localparam int unsigned CNT_W  = $clog2(N_VERT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CLOSE = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          count;
    logic signed [ACC_W-1:0]   acc;
    logic [COORD_W-1:0]        first_x;
    logic [COORD_W-1:0]        first_y;
    logic [COORD_W-1:0]        prev_x;
    logic [COORD_W-1:0]        prev_y;

    // One shoelace term a.x*b.y - b.x*a.y on zero-extended products.
    function automatic logic signed [ACC_W-1:0] cross_term(
        input logic [COORD_W-1:0] ax,
        input logic [COORD_W-1:0] ay,
        input logic [COORD_W-1:0] bx,
        input logic [COORD_W-1:0] by
    );
        logic [PROD_W-1:0] p;
        logic [PROD_W-1:0] q;
        p = PROD_W'(ax) * PROD_W'(by);
        q = PROD_W'(bx) * PROD_W'(ay);
        return $signed(ACC_W'(p)) - $signed(ACC_W'(q));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= '0;
            acc       <= '0;
            first_x   <= '0;
            first_y   <= '0;
            prev_x    <= '0;
            prev_y    <= '0;
            dbl_area  <= '0;
            ccw       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // busy mirrors CLOSE/OUT, so any vertex offered now is lost
            if (in_valid && busy) begin
                drop_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        first_x <= inX;
                        first_y <= inY;
                        prev_x  <= inX;
                        prev_y  <= inY;
                        count   <= CNT_W'(1);
                        acc     <= '0;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc    <= acc + cross_term(prev_x, prev_y, inX, inY);
                        prev_x <= inX;
                        prev_y <= inY;
                        count  <= count + CNT_W'(1);
                        if (count == CNT_W'(N_VERT - 1)) begin
                            state <= S_CLOSE;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_CLOSE: begin
                    acc   <= acc + cross_term(prev_x, prev_y, first_x, first_y);
                    state <= S_OUT;
                end
                S_OUT: begin
                    dbl_area  <= AREA_W'(acc[ACC_W-1] ? -acc : acc);
                    ccw       <= !acc[ACC_W-1] && (acc != '0);
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
